// File: rtl/keynsham_bus_initiator_pkg.sv
// Shared keynsham bus definitions: FSM state encoding and bus address geometry,
// reused by the initiator and the cs_gen-based slaves.
package keynsham_bus_initiator_pkg;

    localparam int BUS_ADDR_W = 30;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_e;

    // Byte address to bus word address; the two lane-select bits are dropped.
    function automatic logic [BUS_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/keynsham_bus_initiator.sv
// Keynsham bus master front end: one request in, one bus transaction out,
// one response back, with an optional ack/error timeout.
module keynsham_bus_initiator
    import keynsham_bus_initiator_pkg::*;
#(
    parameter int unsigned timeout_cycles = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_wr,
    input  logic [31:0]           req_wr_val,
    input  logic [3:0]            req_bytesel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  bus_access,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic [31:0]           bus_wr_val,
    output logic                  bus_wr_en,
    output logic [3:0]            bus_bytesel,
    input  logic                  bus_ack,
    input  logic                  bus_error,
    input  logic [31:0]           bus_data,
    output logic                  busy
);

    localparam int CNT_W = (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  bus_access_q, bus_access_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]           bus_wr_val_q, bus_wr_val_d;
    logic                  bus_wr_en_q, bus_wr_en_d;
    logic [3:0]            bus_bytesel_q, bus_bytesel_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_access_d  = bus_access_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_val_d  = bus_wr_val_q;
        bus_wr_en_d   = bus_wr_en_q;
        bus_bytesel_d = bus_bytesel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = ACCESS;
                    cnt_d         = '0;
                    bus_access_d  = 1'b1;
                    bus_addr_d    = word_addr(req_addr);
                    bus_wr_val_d  = req_wr_val;
                    bus_wr_en_d   = req_wr;
                    bus_bytesel_d = req_bytesel;
                end
            end
            ACCESS: begin
                // A slave answer on the timeout edge takes priority over the timeout.
                if (bus_ack || bus_error) begin
                    state_d       = RESP;
                    bus_access_d  = 1'b0;
                    bus_wr_en_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = bus_error;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = (bus_error || bus_wr_en_q) ? 32'h0 : bus_data;
                end else if ((timeout_cycles != 0) && (cnt_q == CNT_LAST)) begin
                    state_d       = RESP;
                    bus_access_d  = 1'b0;
                    bus_wr_en_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 32'h0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_access_q  <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_val_q  <= 32'h0;
            bus_wr_en_q   <= 1'b0;
            bus_bytesel_q <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'h0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_access_q  <= bus_access_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_val_q  <= bus_wr_val_d;
            bus_wr_en_q   <= bus_wr_en_d;
            bus_bytesel_q <= bus_bytesel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign bus_access  = bus_access_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_val  = bus_wr_val_q;
    assign bus_wr_en   = bus_wr_en_q;
    assign bus_bytesel = bus_bytesel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_keynsham_bus_initiator.sv
// Directed bench for keynsham_bus_initiator: a hand-driven slave, a response
// scoreboard and cycle-level checks of the bus and handshake signals.
module tb_keynsham_bus_initiator;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_wr = 1'b0;
    logic [31:0] req_wr_val = 32'h0;
    logic [3:0]  req_bytesel = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        bus_access;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic        bus_wr_en;
    logic [3:0]  bus_bytesel;
    logic        bus_ack = 1'b0;
    logic        bus_error = 1'b0;
    logic [31:0] bus_data = 32'h0;
    logic        busy;

    keynsham_bus_initiator #(.timeout_cycles(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_wr_val(req_wr_val), .req_bytesel(req_bytesel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .bus_access(bus_access), .bus_addr(bus_addr), .bus_wr_val(bus_wr_val),
        .bus_wr_en(bus_wr_en), .bus_bytesel(bus_bytesel),
        .bus_ack(bus_ack), .bus_error(bus_error), .bus_data(bus_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
        logic        timeout;
    } rsp_t;

    rsp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          txn   = 0;
    logic [31:0] cur_addr;
    logic        cur_wr;
    logic [31:0] cur_val;
    logic [3:0]  cur_bs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bus_held(input string tag);
        check({tag, "_access"}, {31'h0, bus_access}, 32'h1);
        check({tag, "_addr"}, {2'b00, bus_addr}, {2'b00, cur_addr[31:2]});
        check({tag, "_wr_en"}, {31'h0, bus_wr_en}, {31'h0, cur_wr});
        check({tag, "_wr_val"}, bus_wr_val, cur_val);
        check({tag, "_bytesel"}, {28'h0, bus_bytesel}, {28'h0, cur_bs});
    endtask

    // Present a request at a falling edge and check it is on the bus one cycle later.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] v,
                          input logic [3:0] bs);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_addr = a; req_wr = w; req_wr_val = v; req_bytesel = bs;
        cur_addr = a; cur_wr = w; cur_val = v; cur_bs = bs;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wr = ~w; req_wr_val = $urandom;
        req_bytesel = 4'($urandom);
        check_bus_held("accept");
        check("accept_req_ready", {31'h0, req_ready}, 32'h0);
        check("accept_busy", {31'h0, busy}, 32'h1);
    endtask

    // Hold off for wait_n cycles, then answer once; push the expected response.
    task automatic slave_reply(input int wait_n, input logic ack, input logic err,
                               input logic [31:0] data);
        rsp_t e;
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            check_bus_held("hold");
            check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end
        bus_ack = ack; bus_error = err; bus_data = data;
        e.data = (err || cur_wr) ? 32'h0 : data;
        e.error = err;
        e.timeout = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        bus_ack = 1'b0; bus_error = 1'b0; bus_data = $urandom;
        check("exit_access", {31'h0, bus_access}, 32'h0);
        check("exit_wr_en", {31'h0, bus_wr_en}, 32'h0);
        check("exit_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    endtask

    // Stall rsp_ready for hold_n cycles, then complete the handshake and score it.
    task automatic take_rsp(input int hold_n);
        rsp_t e;
        rsp_t snap;
        snap = {rsp_data, rsp_error, rsp_timeout};
        for (int i = 0; i < hold_n; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_rsp_stable", {rsp_data[30:0], rsp_error}, {snap.data[30:0], snap.error});
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
            check("stall_bus_access", {31'h0, bus_access}, 32'h0);
        end
        check("sb_nonempty", {31'h0, exp_q.size() > 0}, 32'h1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("rsp_data", rsp_data, e.data);
            check("rsp_error", {31'h0, rsp_error}, {31'h0, e.error});
            check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.timeout});
            $display("[TB] txn %0d addr=%h wr=%0d data=%h err=%0d tmo=%0d",
                     txn, cur_addr, cur_wr, rsp_data, rsp_error, rsp_timeout);
            txn++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("post_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rsp_data_kept", rsp_data, e.data);
    endtask

    initial begin
        int n;
        rsp_t e;

        // Reset state
        #12;
        check("rst_bus_access", {31'h0, bus_access}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_bus_addr", {2'b00, bus_addr}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_bus_bytesel", {28'h0, bus_bytesel}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // 1: read, single-cycle slave
        do_req(32'h8000_0104, 1'b0, 32'h0, 4'hF);
        check("t1_bus_addr", {2'b00, bus_addr}, 32'h2000_0041);
        slave_reply(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        take_rsp(0);

        // 2: write, slave answers after 3 cycles
        do_req(32'h0000_0010, 1'b1, 32'h0000_1234, 4'b0011);
        slave_reply(3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        take_rsp(0);

        // 3: slave error together with ack, zero byte enables passed through
        do_req(32'h4000_0008, 1'b0, 32'h0, 4'b0000);
        slave_reply(1, 1'b1, 1'b1, 32'h1234_5678);
        take_rsp(1);

        // 4: no answer, timeout after TMO access cycles; late ack ignored
        do_req(32'h0000_0FFC, 1'b0, 32'h0, 4'hF);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus_access) break;
            n++;
        end
        check("t4_access_cycles", n, TMO);
        e.data = 32'h0; e.error = 1'b1; e.timeout = 1'b1;
        exp_q.push_back(e);
        check("t4_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        take_rsp(0);
        @(negedge clk);
        bus_ack = 1'b1; bus_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        check("t4_late_busy", {31'h0, busy}, 32'h0);
        check("t4_late_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("t4_late_access", {31'h0, bus_access}, 32'h0);

        // 5: response back-pressure with a second request waiting
        do_req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        slave_reply(1, 1'b1, 1'b0, 32'h0BAD_F00D);
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_wr = 1'b1;
        req_wr_val = 32'hA5A5_5A5A; req_bytesel = 4'b1100;
        take_rsp(5);
        do_req(32'h0000_0300, 1'b1, 32'hA5A5_5A5A, 4'b1100);
        slave_reply(0, 1'b1, 1'b0, 32'h7777_7777);
        take_rsp(0);

        // 6: asynchronous reset in the middle of an access
        do_req(32'h0000_0400, 1'b1, 32'h0000_00FF, 4'b0001);
        #2 rst = 1'b0;
        #1;
        check("t6_async_access", {31'h0, bus_access}, 32'h0);
        check("t6_async_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_req_ready", {31'h0, req_ready}, 32'h1);
        check("t6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("t6_sb_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keynsham_bus_initiator.md
Name: keynsham_bus_initiator

Overview:
- Bus master front end for the keynsham system bus.
- Turns a valid/ready request stream (CPU debug port, DMA, test harness) into single bus transactions of the form that peripheral blocks such as the timer block answer.
- Holds the bus until a slave returns ack or error, or until a timeout expires.
- Returns a response on a valid/ready stream. One outstanding transaction at a time.

Parameters:
timeout_cycles, 256, bus cycles to wait for ack/error before aborting; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  initiator can accept a request
req_addr  in  32  byte address; bits [1:0] are ignored
req_wr  in  1  1 = write, 0 = read
req_wr_val  in  32  write data
req_bytesel  in  4  byte lane enables
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  read data; 0 for writes and errors
rsp_error  out  1  transaction failed (slave error or timeout)
rsp_timeout  out  1  failure was a timeout
bus_access  out  1  transaction strobe
bus_addr  out  30  word address = req_addr[31:2]
bus_wr_val  out  32  write data to slaves
bus_wr_en  out  1  write enable
bus_bytesel  out  4  byte lane enables
bus_ack  in  1  slave completed the access
bus_error  in  1  slave rejected the access
bus_data  in  32  slave read data, valid in the ack cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE.
  - req_ready=1 after deassert; rsp_valid=0, rsp_data=0, rsp_error=0, rsp_timeout=0.
  - bus_access=0, bus_addr=0, bus_wr_val=0, bus_wr_en=0, bus_bytesel=0, busy=0.
  - Timeout counter=0.
- All bus_* and rsp_* outputs are registered. req_ready = (state==IDLE), combinational from state.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: on req_valid & req_ready at edge N:
  - Latch addr[31:2], wr, wr_val, bytesel into bus_* registers.
  - bus_access=1 and bus_wr_en=req_wr from cycle N+1. Clear the counter.
- ACCESS:
  - bus_access, bus_addr, bus_wr_en, bus_wr_val and bus_bytesel are held stable until exit.
  - The counter increments each cycle.
  - Exit on the first edge where bus_ack | bus_error is sampled high: bus_access=0 and bus_wr_en=0 the next cycle; enter RESP with rsp_valid=1.
  - ack only: rsp_error=0; rsp_data=bus_data for reads, 0 for writes.
  - error (with or without ack): rsp_error=1, rsp_data=0. Error wins.
  - Timeout: if timeout_cycles!=0 and the counter reaches timeout_cycles-1 with no ack/error, exit the same way with rsp_error=1, rsp_timeout=1, rsp_data=0.
  - An ack arriving on the same edge as the timeout wins; that transaction is not a timeout.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid=0 and return to IDLE next cycle. rsp_data, rsp_error and rsp_timeout keep their values until the next response.
  - bus_ack and bus_error are ignored in RESP and IDLE (late ack after a timeout is dropped).
- Latency: a request accepted at edge N with a slave acking in cycle N+2 (single-cycle slave) gives rsp_valid high from N+3. Minimum request-to-request spacing is 4 cycles.
- bus_bytesel == 0 is passed through unchanged; no local checking.
- The counter is $clog2(timeout_cycles+1) bits wide and saturates; it never wraps.
- Reset mid-ACCESS drops bus_access immediately (asynchronously). No response is generated.

Decomposition:
- Shared keynsham package gets:
  - State encoding localparams (IDLE/ACCESS/RESP).
  - A bus word-address width constant (30), reused by the cs_gen-based slaves.
- No sub-module. The timeout counter is inline.

Test Plan:
1. Read, slave acks 1 cycle after bus_access: req_addr=32'h8000_0104 -> bus_addr=30'h2000_0041, bus_wr_en=0; bus_data=32'hDEADBEEF in the ack cycle; rsp_valid at N+3, rsp_data=32'hDEADBEEF, rsp_error=0.
2. Write with bytesel=4'b0011, wr_val=32'h0000_1234, ack after 3 cycles -> bus signals stable 3 cycles; rsp_data=0, rsp_error=0; bus_access low the cycle after ack.
3. Slave asserts bus_error (and ack) -> rsp_error=1, rsp_timeout=0, rsp_data=0.
4. No ack, timeout_cycles=8 -> bus_access high exactly 8 cycles; rsp_error=1, rsp_timeout=1; ack injected 2 cycles later is ignored, state stays IDLE.
5. rsp_ready held low 5 cycles with a second req_valid pending -> rsp_* stable, req_ready=0 throughout; the second request is accepted only after the handshake.
6. rst pulled low mid-ACCESS -> bus_access=0 and busy=0 asynchronously; after release req_ready=1 and rsp_valid=0.
